// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 16-bit course CPU execute stage.
// Holds the datapath width and the multiplier FSM state encoding.
package cpu_defs;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_mul_unit.sv
// Iterative unsigned shift-add multiplier, WIDTH+1 cycle fixed latency.
// Optional MUL_OVF_EN widens acc/multiplicand and registers an overflow flag.
module shift_mul_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

`ifdef MUL_OVF_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] mcand_q, mcand_d;
    logic [ACC_W-1:0] acc_sum;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MUL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state, counter and shift-add datapath; everything holds by default.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef MUL_OVF_EN
        ovf_d    = ovf_q;
`endif
        acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        unique case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = ACC_W'(op_a);
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL_RUN;
                end
            end
            MUL_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = MUL_DONE;
                    result_d = acc_sum[WIDTH-1:0];
`ifdef MUL_OVF_EN
                    ovf_d    = |acc_sum[ACC_W-1:WIDTH];
`endif
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef MUL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef MUL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q != MUL_IDLE);
    assign done   = (state_q == MUL_DONE);
    assign result = result_q;
`ifdef MUL_OVF_EN
    assign ovf    = ovf_q;
`else
    assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_shift_mul_unit.sv
// Directed bench for shift_mul_unit: vector table plus corner sequences.
// Honours MUL_OVF_EN for the expected overflow flag.
module tb_shift_mul_unit;

`ifdef MUL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;

    int checks;
    int failures;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         o;
    } vec_t;

    vec_t vecs[9];

    shift_mul_unit #(.WIDTH(W), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present operands, accept on the next edge, then scramble the inputs.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
    endtask

    task automatic do_mul(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er,
                          input logic eo);
        int n;
        int bc;
        n  = 0;
        bc = 0;
        accept(a, b);
        if (busy) bc++;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
            if (done) break;
            if (n > 40) begin
                failures++;
                $display("FAIL %s_timeout: got no done expected done", nm);
                break;
            end
        end
        chk({nm, "_lat"}, n, W);
        chk({nm, "_busy"}, bc, W + 1);
        chk({nm, "_res"}, result, er);
        chk({nm, "_ovf"}, ovf, eo & OVF_EN);
        @(posedge clk);
        #1;
        chk({nm, "_idle"}, {busy, done}, 2'b00);
        chk({nm, "_hold"}, result, er);
    endtask

    initial begin
        int dc;
        int k;
        int last;
        logic [W-1:0] prev_r;
        logic         prev_o;
        logic [W-1:0] exp6[3];
        logic [W-1:0] pa6[3];
        logic [W-1:0] pb6[3];

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;

        vecs[0] = '{16'd3,    16'd5,    16'h000F, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1};
        vecs[2] = '{16'h0000, 16'h1234, 16'h0000, 1'b0};
        vecs[3] = '{16'hABCD, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'h0001, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[5] = '{16'h0100, 16'h0100, 16'h0000, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0101, 16'hFFFF, 1'b0};
        vecs[7] = '{16'h8000, 16'h0002, 16'h0000, 1'b1};
        vecs[8] = '{16'h1234, 16'h0002, 16'h2468, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {busy, done, ovf, result}, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].r, vecs[i].o);
        end

        // Asynchronous reset in idle with a nonzero held result.
        do_mul("pre_rst", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst", {busy, done, ovf, result}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Start pulses during RUN and DONE are ignored.
        accept(16'd7, 16'd9);
        dc = 0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (done) dc++;
            if (n == 5) begin
                start = 1'b1;
                op_a  = 16'd2;
                op_b  = 16'd2;
            end
            if (n == 6) start = 1'b0;
        end
        chk("ign_done", {done, dc[0]}, 2'b11);
        chk("ign_res", result, 16'h003F);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_idle", busy, 1'b0);
        dc = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) dc++;
        end
        chk("ign_nosecond", dc, 0);
        chk("ign_keep", result, 16'h003F);

        // Reset at iteration 8 aborts the multiply.
        accept(16'h1234, 16'h0002);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_out", {busy, done, ovf, result}, '0);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) dc++;
        end
        chk("abort_nodone", dc, 0);
        do_mul("after_abort", 16'h1234, 16'h0002, 16'h2468, 1'b0);

        // Start held high: done every WIDTH+2 cycles.
        pa6[0] = 16'h0011; pb6[0] = 16'h0003; exp6[0] = 16'h0033;
        pa6[1] = 16'h0101; pb6[1] = 16'h0002; exp6[1] = 16'h0202;
        pa6[2] = 16'h00FF; pb6[2] = 16'h0101; exp6[2] = 16'hFFFF;
        @(posedge clk);
        #1;
        op_a   = pa6[0];
        op_b   = pb6[0];
        start  = 1'b1;
        prev_r = result;
        prev_o = ovf;
        k      = 0;
        last   = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (k < 3) chk($sformatf("b2b_res%0d", k), result, exp6[k]);
                if (k > 0) chk($sformatf("b2b_per%0d", k), c - last, W + 2);
                last = c;
                k++;
                if (k < 3) begin
                    op_a = pa6[k];
                    op_b = pb6[k];
                end
            end else begin
                chk("b2b_stable", {ovf, result}, {prev_o, prev_r});
            end
            prev_r = result;
            prev_o = ovf;
        end
        start = 1'b0;
        chk("b2b_count", k, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
